// File: rtl/freq_gen_pkg.sv
// Shared constants and sizing helpers for the programmable square-wave generator.
package freq_gen_pkg;

  localparam int SEL_W_DEFAULT = 4;

  // Half-period length in clock cycles for select code k.
  function automatic int unsigned half_period(input int unsigned base, input int unsigned k);
    return base * (k + 32'd1);
  endfunction

  // Counter width large enough to hold the longest half-period without wrapping.
  function automatic int cnt_width(input int base, input int sel_w);
    return $clog2(base * (32'sd1 << sel_w)) + 32'sd1;
  endfunction

endpackage

// File: rtl/freq_generator.sv
// Divides the system clock into a 50%-duty square wave plus a rise-aligned tick.
// Define FREQ_GEN_LATCH_SEL_EN to sample inp_freq only at half-period boundaries.
module freq_generator
  import freq_gen_pkg::*;
#(
  parameter int BASE_DIV = 250,
  parameter int SEL_W    = SEL_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] inp_freq,
  output logic             freq_out,
  output logic             freq_tick
);

  localparam int CNT_W = cnt_width(BASE_DIV, SEL_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] limit_s;
  logic [SEL_W-1:0] sel_s;
  logic             wrap_s;

`ifdef FREQ_GEN_LATCH_SEL_EN
  logic [SEL_W-1:0] sel_q;

  // Capture the select code only when a half-period ends, so each one runs complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q <= {SEL_W{1'b0}};
    end else if (wrap_s) begin
      sel_q <= inp_freq;
    end else begin
      sel_q <= sel_q;
    end
  end

  assign sel_s = sel_q;
`else
  assign sel_s = inp_freq;
`endif

  // A >= compare lets a shortened half-period end on the very next edge.
  always_comb begin
    limit_s = CNT_W'(half_period(32'(BASE_DIV), 32'(sel_s))) - CNT_ONE;
    wrap_s  = (cnt_r >= limit_s);
  end

  // Half-period counter, square-wave toggle register and rise tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      freq_out  <= 1'b0;
      freq_tick <= 1'b0;
    end else if (wrap_s) begin
      cnt_r     <= {CNT_W{1'b0}};
      freq_out  <= ~freq_out;
      freq_tick <= ~freq_out;
    end else begin
      cnt_r     <= cnt_r + CNT_ONE;
      freq_out  <= freq_out;
      freq_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_generator.sv
// Scoreboard bench for freq_generator: a divide-by-2 unit instance driven with directed
// and random select codes, plus a divide-by-1 unit instance run at code 0.
module tb_freq_generator;

`ifdef FREQ_GEN_LATCH_SEL_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset2, reset1;
  logic [3:0] sel2, sel1;
  logic       out2, tick2, out1, tick1;

  int checks = 0;
  int errors = 0;

  logic [1:0] q2[$];
  logic [1:0] q1[$];
  logic [1:0] e2, e1;

  // Reference state: cycles spent in current half-period, wave level, latched code.
  int m_el[2];
  bit m_out[2];
  int m_sq[2];

  always #5 clock = ~clock;

  freq_generator #(.BASE_DIV(2), .SEL_W(4)) u_div2 (
    .clock(clock), .reset(reset2), .inp_freq(sel2), .freq_out(out2), .freq_tick(tick2));

  freq_generator #(.BASE_DIV(1), .SEL_W(4)) u_div1 (
    .clock(clock), .reset(reset1), .inp_freq(sel1), .freq_out(out1), .freq_tick(tick1));

  function automatic int base_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Predicts {freq_out, freq_tick} after the next rising edge.
  function automatic logic [1:0] model_step(input int d, input bit rst, input int s);
    int   used;
    int   h;
    logic tk;
    if (rst) begin
      m_el[d]  = 0;
      m_out[d] = 1'b0;
      m_sq[d]  = 0;
      return 2'b00;
    end
    used = LATCH ? m_sq[d] : s;
    h    = base_of(d) * (used + 1);
    if (m_el[d] + 1 >= h) begin
      tk       = !m_out[d];
      m_out[d] = !m_out[d];
      m_el[d]  = 0;
      m_sq[d]  = s;
    end else begin
      m_el[d]  = m_el[d] + 1;
      tk       = 1'b0;
    end
    return {m_out[d], tk};
  endfunction

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got out,tick=%b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r2, input bit r1, input int s);
    @(negedge clock);
    reset2 = r2;
    reset1 = r1;
    sel2   = 4'(s);
    sel1   = 4'd0;
    q2.push_back(model_step(0, r2, s));
    q1.push_back(model_step(1, r1, 0));
  endtask

  // Monitor: compare each DUT against the oldest queued prediction after every edge.
  always @(posedge clock) begin
    #1;
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("div2_wave", {out2, tick2}, e2);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("div1_wave", {out1, tick1}, e1);
    end
  end

  initial begin
    int  cur;
    bit  found;
    reset2 = 1'b1;
    reset1 = 1'b1;
    sel2   = 4'd0;
    sel1   = 4'd0;
    #2;
    chk("reset_state_div2", {out2, tick2}, 2'b00);
    chk("reset_state_div1", {out1, tick1}, 2'b00);
    repeat (3) cyc(1'b1, 1'b1, 0);

    // k=0, H=2: period 4
    repeat (24) cyc(1'b0, 1'b0, 0);

    // k=15, H=32: ten full periods
    repeat (2) cyc(1'b1, 1'b0, 15);
    repeat (650) cyc(1'b0, 1'b0, 15);

    // Select lowered mid half-period
    repeat (2) cyc(1'b1, 1'b0, 15);
    repeat (21) cyc(1'b0, 1'b0, 15);
    repeat (20) cyc(1'b0, 1'b0, 0);
    repeat (30) cyc(1'b0, 1'b0, 15);
    repeat (20) cyc(1'b0, 1'b0, 0);

    // Random select changes
    repeat (2) cyc(1'b1, 1'b0, 0);
    cur = 0;
    repeat (900) begin
      if ($urandom_range(0, 19) == 0) cur = int'($urandom_range(0, 15));
      cyc(1'b0, 1'b0, cur);
    end

    // Asynchronous reset in the middle of a high phase
    repeat (2) cyc(1'b1, 1'b0, 15);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1'b0, 1'b0, 15);
      if (m_out[0] && m_el[0] == 10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_high_search: got no high phase, required one within 300 cycles");
    end
    @(posedge clock);
    #3;
    reset2 = 1'b1;
    #1;
    chk("async_reset", {out2, tick2}, 2'b00);
    repeat (2) cyc(1'b1, 1'b0, 15);
    repeat (80) cyc(1'b0, 1'b0, 15);

    repeat (3) @(negedge clock);
    checks++;
    if (q2.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending predictions, required 0", q2.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
